psu_cwdarr_serializer: RTL and testbench
========================================

// Module: psu_cwdarr_serializer
// PURPOSE
//  Downstream stage of the PSU codeword-array generator. Accepts one full
//  codeword array per handshake (NUM_PQ codewords, CWD_BW bits each) into a
//  2-entry buffer. Streams each array to the QCI-side link as NUM_PQ/CHUNK_PQ
//  chunks under valid/ready flow control. Decouples array generation from the
//  narrower physical-qubit control link.
// PARAMETERS
//  NUM_PQ    `NUM_PQ   number of physical qubits per codeword array
//  CWD_BW    `CWD_BW   bits per codeword
//  CHUNK_PQ  8         codewords per output chunk; NUM_PQ % CHUNK_PQ == 0 required
//  (derived) NUM_CHUNK = NUM_PQ/CHUNK_PQ; CIDX_BW = max(1,$clog2(NUM_CHUNK))
// PORTS
//  clk         in   1                  clock, rising edge
//  rst_n       in   1                  asynchronous reset, active-low
//  in_valid    in   1                  cwdarray_in holds a valid array
//  in_ready    out  1                  buffer can accept an array
//  cwdarray_in in   NUM_PQ*CWD_BW      array; qubit i at [i*CWD_BW +: CWD_BW]
//  out_valid   out  1                  out_chunk valid
//  out_ready   in   1                  consumer accepts out_chunk
//  out_chunk   out  CHUNK_PQ*CWD_BW    codewords of qubits idx*CHUNK_PQ .. +CHUNK_PQ-1
//  out_idx     out  CIDX_BW            chunk index within current array
//  out_last    out  1                  out_idx == NUM_CHUNK-1
//  arr_cnt     out  16                 arrays fully sent since reset; wraps at 2^16
//  busy        out  1                  buffer non-empty
// BEHAVIOUR
//  - Reset (rst_n low, async): occupancy=0, chunk counter=0, arr_cnt=0,
//    out_valid=0, busy=0, out_chunk/out_idx=0, out_last=0; in_ready forced 0
//    while rst_n low, 1 from first clk edge after deassertion.
//  - Occupancy state EMPTY(0) / ONE(1) / FULL(2); buffer is FIFO (head/tail ptr).
//  - in_ready = (occupancy != FULL) and rst_n; depends on registered state
//    only, never on out_ready (no pass-through when FULL).
//  - Push: in_valid & in_ready at edge -> array written to tail entry.
//  - out_valid = (occupancy != EMPTY), registered. First chunk appears the
//    cycle after the push edge (1-cycle latency from EMPTY).
//  - out_chunk = head[idx*CHUNK_PQ*CWD_BW +: CHUNK_PQ*CWD_BW]; chunk 0 = LSBs.
//  - Chunk advance on out_valid & out_ready: idx++ ; when idx==NUM_CHUNK-1 the
//    head entry is popped, idx->0, arr_cnt++ (wraps 0xFFFF->0).
//  - Push and pop in same cycle: occupancy unchanged; legal in ONE; in FULL
//    only the pop occurs (in_ready was 0). Pointers wrap mod 2.
//  - Stall: while out_valid & !out_ready, out_chunk/out_idx/out_last stable.
//  - Throughput: one array per NUM_CHUNK cycles with out_ready held 1; no
//    bubble between consecutive arrays when next array already buffered.
//  - in_valid while in_ready=0: ignored, no state change; producer holds data.
//  - NUM_CHUNK==1: every chunk is last; out_idx constant 0.
//  - Reset mid-stream: buffered arrays discarded, partial array not completed.
// TESTING  (NUM_PQ=16, CWD_BW=4, CHUNK_PQ=4 unless noted)
//  1 reset, push A=64'hFEDCBA9876543210, out_ready=1 -> chunks 16'h3210,
//    16'h7654, 16'hBA98, 16'hFEDC on 4 consecutive cycles starting cycle
//    after push, idx 0..3, last on idx 3, arr_cnt=1.
//  2 out_ready=0, push A,B -> in_ready=0 after 2nd push; third in_valid
//    ignored; chunk 0 of A held stable 10 cycles; release -> A then B, 8 cycles.
//  3 push during last chunk of A while ONE -> B chunk 0 next cycle, no bubble,
//    occupancy stays ONE.
//  4 random out_ready (50%), 1000 random arrays -> scoreboard reassembly
//    matches inputs, arr_cnt=1000 mod 2^16.
//  5 assert rst_n low mid-array (idx=2, FULL) -> out_valid=0 immediately,
//    after release occupancy 0, in_ready=1, arr_cnt=0.
//  6 CHUNK_PQ=16 -> single chunk per array, out_last=1 always, arr_cnt++ per beat.

Source files
------------

// File: rtl/psu_cwdarr_serializer.sv
// psu_cwdarr_serializer: 2-entry codeword-array FIFO that streams each
// buffered array to the QCI link as NUM_PQ/CHUNK_PQ chunks, LSB chunk first.
module psu_cwdarr_serializer #(
    parameter int unsigned  NUM_PQ    = 16,
    parameter int unsigned  CWD_BW    = 4,
    parameter int unsigned  CHUNK_PQ  = 8,
    localparam int unsigned NUM_CHUNK = NUM_PQ / CHUNK_PQ,
    localparam int unsigned CIDX_BW   = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_PQ*CWD_BW-1:0]     cwdarray_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHUNK_PQ*CWD_BW-1:0]   out_chunk,
    output logic [CIDX_BW-1:0]           out_idx,
    output logic                         out_last,
    output logic [15:0]                  arr_cnt,
    output logic                         busy
);

    localparam int unsigned ARR_BW = NUM_PQ * CWD_BW;
    localparam int unsigned CHK_BW = CHUNK_PQ * CWD_BW;
    localparam logic [CIDX_BW-1:0] LAST_IDX = CIDX_BW'(NUM_CHUNK - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                occ_q, occ_n;
    logic                head_q, head_n;
    logic                tail_q, tail_n;
    logic [CIDX_BW-1:0]  idx_q, idx_n;
    logic [15:0]         cnt_q, cnt_n;
    logic                rdy_q, valid_q, last_q;
    logic [CHK_BW-1:0]   chunk_q, chunk_n;
    logic [ARR_BW-1:0]   mem_q [2];
    logic [ARR_BW-1:0]   head_data_n;
    logic                push, adv, pop;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_n;
        end
    end

    // Handshakes, next occupancy, pointers, chunk index and next output chunk
    always_comb begin
        push        = in_valid & rdy_q;
        adv         = valid_q & out_ready;
        pop         = adv & (idx_q == LAST_IDX);
        occ_n       = occ_q;
        head_n      = head_q ^ pop;
        tail_n      = tail_q ^ push;
        idx_n       = idx_q;
        cnt_n       = cnt_q;
        head_data_n = mem_q[head_n];
        chunk_n     = '0;

        unique case (occ_q)
            EMPTY: if (push) occ_n = ONE;
            ONE: begin
                if (push && !pop) occ_n = FULL;
                else if (pop && !push) occ_n = EMPTY;
            end
            FULL:    if (pop) occ_n = ONE;
            default: occ_n = EMPTY;
        endcase

        if (pop) begin
            idx_n = '0;
            cnt_n = cnt_q + 16'd1;
        end else if (adv) begin
            idx_n = idx_q + CIDX_BW'(1);
        end

        // The entry becoming head may be the one written on this very edge
        if (push && (tail_q == head_n)) head_data_n = cwdarray_in;

        for (int unsigned c = 0; c < NUM_CHUNK; c++) begin
            if (idx_n == CIDX_BW'(c)) chunk_n = head_data_n[c*CHK_BW +: CHK_BW];
        end
    end

    // Pointers, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= 16'd0;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            chunk_q <= '0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            rdy_q   <= (occ_n != FULL);
            valid_q <= (occ_n != EMPTY);
            last_q  <= (idx_n == LAST_IDX);
            chunk_q <= chunk_n;
        end
    end

    // Array storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= cwdarray_in;
    end

    assign in_ready  = rdy_q;
    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign out_chunk = chunk_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign arr_cnt   = cnt_q;

endmodule

// File: tb/tb_psu_cwdarr_serializer.sv
// Bench for psu_cwdarr_serializer: table-driven first transfer, hand-written
// corner sequences and a randomized run against a queue-level array model.
module tb_psu_cwdarr_serializer;

    localparam logic [63:0] ARR_A = 64'hFEDCBA9876543210;
    localparam logic [63:0] ARR_B = 64'h0123456789ABCDEF;
    localparam logic [63:0] ARR_C = 64'h5555AAAA3333CCCC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // Four-chunk instance
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [63:0] cwdarray_in;
    logic [15:0] out_chunk, arr_cnt;
    logic [1:0]  out_idx;
    // Single-chunk instance
    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, busy16;
    logic [63:0] cwdarray_in16, out_chunk16;
    logic [15:0] arr_cnt16;
    logic [0:0]  out_idx16;

    psu_cwdarr_serializer #(.NUM_PQ(16), .CWD_BW(4), .CHUNK_PQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .cwdarray_in(cwdarray_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk),
        .out_idx(out_idx), .out_last(out_last), .arr_cnt(arr_cnt), .busy(busy)
    );

    psu_cwdarr_serializer #(.NUM_PQ(16), .CWD_BW(4), .CHUNK_PQ(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .cwdarray_in(cwdarray_in16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_chunk(out_chunk16),
        .out_idx(out_idx16), .out_last(out_last16), .arr_cnt(arr_cnt16), .busy(busy16)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: arrays accepted but not yet fully sent, chunk position, sent count
    logic [63:0] mq[$];
    int          mk = 0;
    logic [15:0] mcnt = 16'd0;

    typedef struct {
        logic        v;
        logic [15:0] chunk;
        logic [1:0]  idx;
        logic        last;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock on the four-chunk instance, checked against the model
    task automatic tick(output bit took_in);
        bit          take_in, take_out;
        logic [63:0] d;
        take_in  = in_valid && (mq.size() < 2);
        take_out = out_ready && (mq.size() != 0);
        d        = cwdarray_in;
        if (take_out) begin
            chk("beat_chunk", 64'(out_chunk), 64'(16'(mq[0] >> (16 * mk))));
            chk("beat_idx", 64'(out_idx), 64'(mk));
            chk("beat_last", 64'(out_last), 64'(mk == 3));
        end
        @(posedge clk);
        #1;
        if (take_out) begin
            mk++;
            if (mk == 4) begin
                mk = 0;
                void'(mq.pop_front());
                mcnt++;
            end
        end
        if (take_in) mq.push_back(d);
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("busy", 64'(busy), 64'(mq.size() != 0));
        chk("arr_cnt", 64'(arr_cnt), 64'(mcnt));
        took_in = take_in;
    endtask

    task automatic ticks(input int n);
        bit t;
        for (int i = 0; i < n; i++) tick(t);
    endtask

    initial begin
        bit          t;
        int          pushed, cyc;
        logic [15:0] cnt_before;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; cwdarray_in = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; cwdarray_in16 = '0;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_arr_cnt", 64'(arr_cnt), 64'(0));
        chk("rst_idx", 64'(out_idx), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_chunk", 64'(out_chunk), 64'(0));
        chk("rst_last16", 64'(out_last16), 64'(0));
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_in_ready16", 64'(in_ready16), 64'(1));

        // Single array, consumer always ready: expected cycle-by-cycle outputs
        tbl[0] = '{1'b1, 16'h3210, 2'd0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 16'h7654, 2'd1, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 16'hBA98, 2'd2, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 16'hFEDC, 2'd3, 1'b1, 16'd0};
        tbl[4] = '{1'b0, 16'h0000, 2'd0, 1'b0, 16'd1};
        in_valid = 1'b1; cwdarray_in = ARR_A; out_ready = 1'b1;
        tick(t);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_valid", 64'(out_valid), 64'(tbl[i].v));
            if (tbl[i].v) begin
                chk("t1_chunk", 64'(out_chunk), 64'(tbl[i].chunk));
                chk("t1_idx", 64'(out_idx), 64'(tbl[i].idx));
                chk("t1_last", 64'(out_last), 64'(tbl[i].last));
            end
            chk("t1_cnt", 64'(arr_cnt), 64'(tbl[i].cnt));
            tick(t);
        end

        // Back-pressure: fill to FULL, third offer ignored, head chunk held
        out_ready = 1'b0;
        in_valid = 1'b1; cwdarray_in = ARR_A;
        tick(t);
        cwdarray_in = ARR_B;
        tick(t);
        chk("t2_full_in_ready", 64'(in_ready), 64'(0));
        cwdarray_in = ARR_C;
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_chunk", 64'(out_chunk), 64'(16'h3210));
            chk("t2_hold_idx", 64'(out_idx), 64'(0));
            tick(t);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        ticks(8);
        chk("t2_drained", 64'(out_valid), 64'(0));
        chk("t2_cnt", 64'(arr_cnt), 64'(3));

        // Push during last chunk while ONE: next array follows without a bubble
        in_valid = 1'b1; cwdarray_in = ARR_A;
        tick(t);
        in_valid = 1'b0;
        ticks(3);
        chk("t3_at_last", 64'(out_idx), 64'(3));
        in_valid = 1'b1; cwdarray_in = ARR_B;
        tick(t);
        in_valid = 1'b0;
        chk("t3_no_bubble", 64'(out_valid), 64'(1));
        chk("t3_b_chunk0", 64'(out_chunk), 64'(16'hCDEF));
        chk("t3_b_idx0", 64'(out_idx), 64'(0));
        chk("t3_still_one", 64'(in_ready), 64'(1));
        ticks(4);
        chk("t3_cnt", 64'(arr_cnt), 64'(5));

        // Randomized traffic against the model
        cnt_before = arr_cnt;
        pushed = 0;
        cyc = 0;
        cwdarray_in = {$urandom(), $urandom()};
        while (pushed < 1000 && cyc < 30000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = $urandom_range(0, 1) == 1;
            tick(t);
            if (t) begin
                pushed++;
                cwdarray_in = {$urandom(), $urandom()};
            end
            cyc++;
        end
        chk("t4_all_pushed", 64'(pushed), 64'(1000));
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (mq.size() != 0 && cyc < 200) begin
            tick(t);
            cyc++;
        end
        chk("t4_drain_done", 64'(mq.size()), 64'(0));
        chk("t4_arr_cnt", 64'(arr_cnt), 64'(16'(cnt_before + 16'd1000)));

        // Reset mid-array with the buffer FULL
        out_ready = 1'b0; in_valid = 1'b1; cwdarray_in = ARR_A;
        tick(t);
        cwdarray_in = ARR_B;
        tick(t);
        in_valid = 1'b0; out_ready = 1'b1;
        ticks(2);
        chk("t5_idx2", 64'(out_idx), 64'(2));
        chk("t5_full", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'(0));
        chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        mq.delete();
        mk = 0;
        mcnt = 16'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'(1));
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_arr_cnt", 64'(arr_cnt), 64'(0));
        chk("t5_idx", 64'(out_idx), 64'(0));
        in_valid = 1'b1; cwdarray_in = ARR_C; out_ready = 1'b1;
        tick(t);
        in_valid = 1'b0;
        ticks(4);
        chk("t5_restart_cnt", 64'(arr_cnt), 64'(1));

        // Single chunk per array: every beat is last, count per beat
        in_valid16 = 1'b1; cwdarray_in16 = ARR_A; out_ready16 = 1'b1;
        @(posedge clk);
        #1;
        cwdarray_in16 = ARR_B;
        chk("t6_valid_a", 64'(out_valid16), 64'(1));
        chk("t6_chunk_a", out_chunk16, ARR_A);
        chk("t6_last_a", 64'(out_last16), 64'(1));
        chk("t6_idx_a", 64'(out_idx16), 64'(0));
        chk("t6_cnt0", 64'(arr_cnt16), 64'(0));
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        chk("t6_valid_b", 64'(out_valid16), 64'(1));
        chk("t6_chunk_b", out_chunk16, ARR_B);
        chk("t6_last_b", 64'(out_last16), 64'(1));
        chk("t6_cnt1", 64'(arr_cnt16), 64'(1));
        @(posedge clk);
        #1;
        chk("t6_idle", 64'(out_valid16), 64'(0));
        chk("t6_cnt2", 64'(arr_cnt16), 64'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
